fnd_scan_ctrl: RTL and testbench

Parametrised multiplexed 7-segment (FND) display controller driving NUM_DIGITS common-anode digits from a binary value. A valid/ready load port feeds a sequential double-dabble binary-to-BCD converter, so no combinational divide/modulo logic is needed. The converted value is committed atomically to a display register that a scan engine walks at SCAN_HZ. Adds per-digit decimal points, overflow indication and optional leading-zero blanking; sits between counter/stopwatch datapaths and the board FND pins.

---
 rtl/fnd_pkg.sv | 51 +++++
 rtl/fnd_scan_ctrl_if.sv | 14 +
 rtl/bin2bcd_seq.sv | 86 ++++++++
 rtl/fnd_scan_ctrl.sv | 121 ++++++++++++
 tb/tb_fnd_scan_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/fnd_pkg.sv
// Segment patterns (g..a, active-low), converter state encoding and helpers
// shared by the FND scan controller and its double-dabble engine.
package fnd_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7f;
    localparam logic [6:0] SEG_DASH  = 7'h3f;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_t;

    function automatic logic [63:0] pow10_max(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// Load port of the FND scan controller: value, decimal points, valid/ready.
// master = producer datapath, slave = fnd_scan_ctrl.
interface fnd_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 14
);
    logic                  i_valid;
    logic [DATA_W-1:0]     i_data;
    logic [NUM_DIGITS-1:0] i_dp;
    logic                  o_ready;

    modport master (output i_valid, output i_data, output i_dp, input o_ready);
    modport slave  (input i_valid, input i_data, input i_dp, output o_ready);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: accept -> DATA_W shift cycles -> one-cycle done pulse.
// Ready only in IDLE; requests arriving while busy are dropped, never queued.
module bin2bcd_seq
    import fnd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 14
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_valid,
    input  logic [DATA_W-1:0]       i_data,
    output logic                    o_ready,
    output logic                    o_done,
    output logic [4*NUM_DIGITS-1:0] o_bcd
);
    localparam int            CW   = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    conv_state_t             r_state;
    conv_state_t             w_state_nxt;
    logic [DATA_W-1:0]       r_shift;
    logic [4*NUM_DIGITS-1:0] r_bcd;
    logic [4*NUM_DIGITS-1:0] w_bcd_nxt;
    logic [CW-1:0]           r_cnt;
    logic                    w_accept;

    assign w_accept = i_valid && o_ready;
    assign o_bcd    = r_bcd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (i_valid) w_state_nxt = ST_CONV;
            ST_CONV:   if (r_cnt == LAST) w_state_nxt = ST_COMMIT;
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ready = 1'b0;
        o_done  = 1'b0;
        case (r_state)
            ST_IDLE:   o_ready = 1'b1;
            ST_COMMIT: o_done  = 1'b1;
            default:   ;
        endcase
    end

    // Carries out of the top nibble are dropped; such values are flagged as overflow upstream.
    always_comb begin
        w_bcd_nxt = r_bcd;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_bcd_nxt[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end
        end
        w_bcd_nxt = {w_bcd_nxt[4*NUM_DIGITS-2:0], r_shift[DATA_W-1]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_shift <= i_data;
            r_bcd   <= '0;
            r_cnt   <= '0;
        end else if (r_state == ST_CONV) begin
            r_shift <= r_shift << 1;
            r_bcd   <= w_bcd_nxt;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed common-anode FND driver: load -> display after DATA_W+1 cycles, digits scanned at SCAN_HZ.
// Loads only while o_ready; FND_LZ_BLANK_EN blanks leading zero digits.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 14,
    parameter int CLK_HZ     = 100_000_000,
    parameter int SCAN_HZ    = 1000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    fnd_scan_ctrl_if.slave        ld,
    output logic                  o_ovf,
    output logic [NUM_DIGITS-1:0] fnd_com,
    output logic [7:0]            fnd_data
);
    localparam int          TICK_DIV = CLK_HZ / SCAN_HZ;
    localparam int          TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int          IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [63:0] MAX      = pow10_max(NUM_DIGITS);

    logic                    w_accept;
    logic                    w_done;
    logic [4*NUM_DIGITS-1:0] w_bcd;
    logic [NUM_DIGITS-1:0]   r_dp_hold;
    logic                    r_ovf_hold;
    logic [4*NUM_DIGITS-1:0] r_disp_bcd;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic                    r_ovf;
    logic [TW-1:0]           r_tick;
    logic                    w_tick;
    logic [IW-1:0]           r_idx;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic [3:0]              w_nib;
    logic [6:0]              w_seg;

    assign w_accept = ld.i_valid && ld.o_ready;

    bin2bcd_seq #(
        .NUM_DIGITS (NUM_DIGITS),
        .DATA_W     (DATA_W)
    ) u_bin2bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (ld.i_valid),
        .i_data  (ld.i_data),
        .o_ready (ld.o_ready),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    // dp and overflow travel alongside the conversion so the commit is atomic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dp_hold  <= '0;
            r_ovf_hold <= 1'b0;
        end else if (w_accept) begin
            r_dp_hold  <= ld.i_dp;
            r_ovf_hold <= 64'(ld.i_data) > MAX;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_disp_bcd <= '0;
            r_disp_dp  <= '0;
            r_ovf      <= 1'b0;
        end else if (w_done) begin
            r_disp_bcd <= w_bcd;
            r_disp_dp  <= r_dp_hold;
            r_ovf      <= r_ovf_hold;
        end
    end

    assign w_tick = (r_tick == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick <= '0;
            r_idx  <= '0;
        end else begin
            r_tick <= w_tick ? '0 : r_tick + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end
        end
    end

`ifdef FND_LZ_BLANK_EN
    logic w_lead;

    // Walk down from the top digit; a lit dp stops blanking for itself and everything below.
    always_comb begin
        w_blank = '0;
        w_lead  = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            w_lead     = w_lead && (r_disp_bcd[4*k +: 4] == 4'd0) && !r_disp_dp[k];
            w_blank[k] = w_lead;
        end
    end
`else
    assign w_blank = '0;
`endif

    assign w_nib = r_disp_bcd[{r_idx, 2'b00} +: 4];

    always_comb begin
        w_seg = seg_decode(w_nib);
        if (r_ovf) begin
            w_seg = SEG_DASH;
        end else if (w_blank[r_idx]) begin
            w_seg = SEG_BLANK;
        end
    end

    assign fnd_com  = ~(NUM_DIGITS'(1) << r_idx);
    assign fnd_data = {~r_disp_dp[r_idx], w_seg};
    assign o_ovf    = r_ovf;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Randomised bench for fnd_scan_ctrl; every cycle is compared against a decimal-arithmetic model.
module tb_fnd_scan_ctrl;
    localparam int ND      = 4;
    localparam int DW      = 14;
    localparam int CLK_HZ  = 1000;
    localparam int SCAN_HZ = 250;
    localparam int TD      = CLK_HZ / SCAN_HZ;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          o_ovf;
    logic [ND-1:0] fnd_com;
    logic [7:0]    fnd_data;

    fnd_scan_ctrl_if #(.NUM_DIGITS(ND), .DATA_W(DW)) ld ();

    fnd_scan_ctrl #(
        .NUM_DIGITS (ND),
        .DATA_W     (DW),
        .CLK_HZ     (CLK_HZ),
        .SCAN_HZ    (SCAN_HZ)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ld       (ld),
        .o_ovf    (o_ovf),
        .fnd_com  (fnd_com),
        .fnd_data (fnd_data)
    );

    always #5 clk = ~clk;

    logic [7:0] seg_tab [10] = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99,
                                 8'h92, 8'h82, 8'hf8, 8'h80, 8'h90};

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: edges since reset release, committed value, pending load.
    int            m_edge;
    int            m_val;
    logic [ND-1:0] m_dp;
    bit            m_ovf;
    bit            m_pend;
    int            m_commit_at;
    int            m_next_ok;
    int            p_val;
    logic [ND-1:0] p_dp;
    bit            p_ovf;
    int            max_val;

    function automatic int pow10(int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, m_edge);
        end
    endtask

    function automatic logic [7:0] exp_data(int idx);
        logic [6:0] s;
        int         d;
        if (m_ovf) begin
            s = 7'h3f;
        end else begin
            d = (m_val / pow10(idx)) % 10;
            s = seg_tab[d][6:0];
`ifdef FND_LZ_BLANK_EN
            if (idx > 0 && m_val < pow10(idx) && (m_dp >> idx) == '0) s = 7'h7f;
`endif
        end
        return {~m_dp[idx], s};
    endfunction

    task automatic model_reset();
        m_edge      = 0;
        m_val       = 0;
        m_dp        = '0;
        m_ovf       = 1'b0;
        m_pend      = 1'b0;
        m_commit_at = 0;
        m_next_ok   = 0;
    endtask

    task automatic check_outputs();
        int            idx;
        logic [ND-1:0] e_com;
        bit            e_rdy;
        idx   = (m_edge / TD) % ND;
        e_com = ~(ND'(1) << idx);
        e_rdy = (m_edge >= m_next_ok - 1);
        chk("fnd_com", 32'(fnd_com), 32'(e_com));
        chk("fnd_data", 32'(fnd_data), 32'(exp_data(idx)));
        chk("o_ready", 32'(ld.o_ready), 32'(e_rdy));
        chk("o_ovf", 32'(o_ovf), 32'(m_ovf));
    endtask

    task automatic step();
        @(posedge clk);
        m_edge++;
        if (m_pend && m_edge == m_commit_at) begin
            m_val  = p_val;
            m_dp   = p_dp;
            m_ovf  = p_ovf;
            m_pend = 1'b0;
        end
        if (ld.i_valid && m_edge >= m_next_ok) begin
            p_val       = int'(ld.i_data);
            p_dp        = ld.i_dp;
            p_ovf       = (p_val > max_val);
            m_pend      = 1'b1;
            m_commit_at = m_edge + DW + 1;
            m_next_ok   = m_edge + DW + 2;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(int v, logic [ND-1:0] dp);
        ld.i_valid = 1'b1;
        ld.i_data  = DW'(v);
        ld.i_dp    = dp;
        step();
        ld.i_valid = 1'b0;
    endtask

    // Called in the low clock phase; reset takes effect without waiting for an edge.
    task automatic async_reset();
        reset_n    = 1'b0;
        ld.i_valid = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        check_outputs();
        reset_n = 1'b1;
    endtask

    initial begin
        int cnt;
        int v;
        int mode;
        max_val    = pow10(ND) - 1;
        reset_n    = 1'b0;
        ld.i_valid = 1'b0;
        ld.i_data  = '0;
        ld.i_dp    = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        reset_n = 1'b1;

        run(2 * TD * ND + 1);

        load(1234, 4'b0100);
        cnt = (ld.o_ready == 1'b0) ? 1 : 0;
        for (int i = 0; i < DW + 4; i++) begin
            step();
            if (ld.o_ready == 1'b0) cnt++;
        end
        chk("rdy_low_cycles", 32'(cnt), 32'(DW + 1));
        run(TD * ND);

        load(10000, '0);
        run(DW + 2 + TD * ND);
        load(7, '0);
        run(DW + 2 + TD * ND);

        load(42, '0);
        run(3);
        ld.i_data  = DW'(555);
        ld.i_valid = 1'b1;
        step();
        ld.i_valid = 1'b0;
        run(3);
        ld.i_data  = DW'(77);
        ld.i_valid = 1'b1;
        run(DW + 4);
        ld.i_valid = 1'b0;
        run(DW + 2 + TD * ND);

        load(9999, '0);
        run(4);
        async_reset();
        run(TD * ND + 2);

        for (int t = 0; t < 60; t++) begin
            mode = int'($urandom_range(0, 2));
            if (mode == 0)      v = int'($urandom_range(0, 99));
            else if (mode == 1) v = int'($urandom_range(0, max_val));
            else                v = int'($urandom_range(0, (1 << DW) - 1));
            ld.i_valid = 1'b1;
            ld.i_data  = DW'(v);
            ld.i_dp    = ND'($urandom);
            run(int'($urandom_range(1, 3)));
            ld.i_valid = 1'b0;
            run(int'($urandom_range(0, 24)));
        end
        run(DW + 2 + TD * ND);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
